// File: rtl/axi_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one AXI-stream tx channel among
// NUM_REQ requesters. Owner holds the channel until its last beat is accepted.
module axi_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int T_DATA_BIT   = 128,
  parameter int T_USER_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*T_DATA_BIT-1:0]      req_data,
  input  logic [NUM_REQ*T_USER_WIDTH-1:0]    req_user,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic                               t_valid,
  input  logic                               t_ready,
  output logic [T_DATA_BIT-1:0]              t_data,
  output logic [T_USER_WIDTH-1:0]            t_user,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               busy
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] sel_idx;
  logic [GW-1:0] xfer_idx;
  logic [GW-1:0] next_ptr;
  logic          sel_found;
  logic          slot_free;
  logic          xfer;
  logic          xfer_last;

  assign slot_free = !t_valid || t_ready;

  // Rotating priority search: rr_ptr first, then rr_ptr+1, ... wrapping.
  always_comb begin
    int unsigned   idx;
    logic [GW-1:0] cand;
    sel_idx   = rr_ptr;
    sel_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = GW'(idx);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign xfer_idx  = (state == LOCKED) ? grant_id : sel_idx;
  assign xfer      = |(req_valid & req_ready);
  assign xfer_last = req_last[xfer_idx];
  assign next_ptr  = (xfer_idx == GW'(NUM_REQ - 1)) ? '0 : xfer_idx + GW'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (xfer) state_nxt = xfer_last ? IDLE : LOCKED;
  end

  // Outputs; rst_n gating keeps req_ready low while reset is held
  always_comb begin
    req_ready = '0;
    busy      = (state == LOCKED);
    if (rst_n && slot_free) begin
      if (state == LOCKED)  req_ready[grant_id] = 1'b1;
      else if (sel_found)   req_ready[sel_idx]  = 1'b1;
    end
  end

  // Registered tx stage, owner index and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_valid  <= 1'b0;
      t_data   <= '0;
      t_user   <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      if (xfer) begin
        t_valid  <= 1'b1;
        t_data   <= req_data[xfer_idx*T_DATA_BIT +: T_DATA_BIT];
        t_user   <= req_user[xfer_idx*T_USER_WIDTH +: T_USER_WIDTH];
        grant_id <= xfer_idx;
        if (xfer_last) rr_ptr <= next_ptr;
      end else if (t_valid && t_ready) begin
        t_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_tx_arbiter.sv
// Scoreboard bench for axi_tx_arbiter: per-requester source queues drive the
// DUT, expected tx beats are queued by hand and checked by a negedge monitor.
module tb_axi_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int UW = 16;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_data;
  logic [N*UW-1:0]   req_user;
  logic [N-1:0]      req_last;
  logic              t_valid;
  logic              t_ready;
  logic [DW-1:0]     t_data;
  logic [UW-1:0]     t_user;
  logic [1:0]        grant_id;
  logic              busy;

  always #5 clk = ~clk;

  axi_tx_arbiter #(.NUM_REQ(N), .T_DATA_BIT(DW), .T_USER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_user(req_user), .req_last(req_last),
    .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data), .t_user(t_user),
    .grant_id(grant_id), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
    int            gap;
  } src_beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    int            gid;
  } exp_beat_t;

  src_beat_t src_mem [N][64];
  int        src_wr [N];
  int        src_rd [N];
  int        gap_cnt [N];
  bit        gap_loaded [N];
  bit        fire [N];
  bit        flush;
  exp_beat_t exp_q [$];

  int tests;
  int fails;
  int beats_seen;
  bit contig;
  bit started;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add_src(input int r, input logic [DW-1:0] d, input logic [UW-1:0] u,
                         input bit last, input int gap);
    src_mem[r][src_wr[r]] = '{d, u, last, gap};
    src_wr[r]++;
  endtask

  task automatic add_exp(input int g, input logic [DW-1:0] d, input logic [UW-1:0] u);
    exp_q.push_back('{d, u, g});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: actual %0d beats outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_beats(input string name, input int target, input int budget);
    int n = 0;
    while (beats_seen < target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    tests++;
    if (beats_seen < target) begin
      fails++;
      $display("FAIL %s_wait: actual %0d beats required %0d", name, beats_seen, target);
    end
  endtask

  function automatic logic [DW-1:0] fdat(input int i, input int p, input int b);
    return DW'(32'h1000 + i * 256 + p * 16 + b);
  endfunction

  function automatic logic [UW-1:0] fusr(input int i, input int p, input int b);
    return UW'(32'hC000 + i * 256 + p * 16 + b);
  endfunction

  // Requester sources: handshake sampled at negedge, next beat presented after posedge
  always begin
    @(negedge clk);
    for (int i = 0; i < N; i++) fire[i] = req_valid[i] && req_ready[i];
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (flush) begin
        src_rd[i] = src_wr[i];
        gap_loaded[i] = 1'b0;
      end else if (fire[i]) begin
        src_rd[i]++;
        gap_loaded[i] = 1'b0;
      end
      if (src_rd[i] < src_wr[i]) begin
        if (!gap_loaded[i]) begin
          gap_cnt[i] = src_mem[i][src_rd[i]].gap;
          gap_loaded[i] = 1'b1;
        end
        if (gap_cnt[i] > 0) begin
          gap_cnt[i]--;
          req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = src_mem[i][src_rd[i]].data;
          req_user[i*UW +: UW] = src_mem[i][src_rd[i]].user;
          req_last[i] = src_mem[i][src_rd[i]].last;
        end
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops plus lock/latency/stall invariants
  int            mid_owner = -1;
  bit            stalled_prev;
  bit            fire_prev;
  logic [DW-1:0] hold_data, fire_data;
  logic [UW-1:0] hold_user, fire_user;

  always @(negedge clk) begin
    exp_beat_t    e;
    logic [N-1:0] others;
    if (!rst_n) begin
      mid_owner    = -1;
      stalled_prev = 1'b0;
      fire_prev    = 1'b0;
    end else begin
      chk("ready_onehot", DW'($countones(req_ready) <= 1), 1);
      if (mid_owner >= 0) begin
        others = req_ready;
        others[mid_owner] = 1'b0;
        chk("busy_locked", busy, 1);
        chk("grant_locked", grant_id, mid_owner);
        chk("lock_others_ready", others, 0);
      end else begin
        chk("busy_idle", busy, 0);
      end
      if (fire_prev) begin
        chk("lat_valid", t_valid, 1);
        chk("lat_data", t_data, fire_data);
        chk("lat_user", t_user, fire_user);
      end
      if (stalled_prev) begin
        chk("stall_valid", t_valid, 1);
        chk("stall_data", t_data, hold_data);
        chk("stall_user", t_user, hold_user);
      end
      if (t_valid && !t_ready) chk("stall_ready", req_ready, 0);
      if (contig && exp_q.size() > 0) begin
        if (t_valid) started = 1'b1;
        if (started) chk("no_bubble", t_valid, 1);
      end
      if (t_valid && t_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: actual %0h required none", t_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", t_data, e.data);
          chk("beat_user", t_user, e.user);
          chk("beat_owner", grant_id, e.gid);
          beats_seen++;
        end
      end
      stalled_prev = t_valid && !t_ready;
      hold_data = t_data;
      hold_user = t_user;
      fire_prev = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          fire_prev = 1'b1;
          fire_data = req_data[i*DW +: DW];
          fire_user = req_user[i*UW +: UW];
          mid_owner = req_last[i] ? -1 : i;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    req_valid = '0; req_data = '0; req_user = '0; req_last = '0;
    t_ready = 1'b1; flush = 1'b0; contig = 1'b0; started = 1'b0;
    tests = 0; fails = 0; beats_seen = 0;
    for (int i = 0; i < N; i++) begin
      src_wr[i] = 0; src_rd[i] = 0; gap_cnt[i] = 0; gap_loaded[i] = 1'b0; fire[i] = 1'b0;
    end
    rst_n = 1'b0;
    #17;
    chk("rst_t_valid", t_valid, 0);
    chk("rst_t_data", t_data, 0);
    chk("rst_t_user", t_user, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Fairness: four requesters, two 2-beat packets each, starting from rr_ptr 0
    contig = 1'b1; started = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++)
        for (int b = 0; b < 2; b++) add_src(i, fdat(i, p, b), fusr(i, p, b), b == 1, 0);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++)
        for (int b = 0; b < 2; b++) add_exp(i, fdat(i, p, b), fusr(i, p, b));
    wait_drain("fairness", 100);
    contig = 1'b0;

    // Single requester 2: 3 beats, leaves rr_ptr at 3
    @(negedge clk); #2;
    add_src(2, 'hA1, 16'h02A1, 1'b0, 0);
    add_src(2, 'hA2, 16'h02A2, 1'b0, 0);
    add_src(2, 'hA3, 16'h02A3, 1'b1, 0);
    add_exp(2, 'hA1, 16'h02A1);
    add_exp(2, 'hA2, 16'h02A2);
    add_exp(2, 'hA3, 16'h02A3);
    wait_drain("single", 50);

    // Backpressure: req 3 must win over req 0 (rr_ptr 3); 5-cycle stall mid-packet
    @(negedge clk); #2;
    base = beats_seen;
    for (int b = 0; b < 4; b++) add_src(3, DW'(32'hB0 + b), UW'(32'h03B0 + b), b == 3, 0);
    add_src(0, 'hC0, 16'h00C0, 1'b1, 0);
    for (int b = 0; b < 4; b++) add_exp(3, DW'(32'hB0 + b), UW'(32'h03B0 + b));
    add_exp(0, 'hC0, 16'h00C0);
    wait_beats("bp", base + 1, 50);
    @(posedge clk); #1;
    t_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    t_ready = 1'b1;
    wait_drain("backpressure", 50);

    // Lock: req 1 (rr_ptr 1) pauses 4 cycles mid-packet while req 0 waits
    @(negedge clk); #2;
    add_src(1, 'hD0, 16'h01D0, 1'b0, 0);
    add_src(1, 'hD1, 16'h01D1, 1'b0, 4);
    add_src(1, 'hD2, 16'h01D2, 1'b1, 0);
    add_src(0, 'hE0, 16'h00E0, 1'b1, 0);
    add_exp(1, 'hD0, 16'h01D0);
    add_exp(1, 'hD1, 16'h01D1);
    add_exp(1, 'hD2, 16'h01D2);
    add_exp(0, 'hE0, 16'h00E0);
    wait_drain("lock", 60);

    // Single-beat packets from reqs 0 and 3 alternate, starting with 3 (rr_ptr 1)
    @(negedge clk); #2;
    for (int k = 0; k < 4; k++) begin
      add_src(0, DW'(32'h00F0 + k), UW'(32'h00F0 + k), 1'b1, 0);
      add_src(3, DW'(32'h03F0 + k), UW'(32'h03F0 + k), 1'b1, 0);
    end
    for (int k = 0; k < 4; k++) begin
      add_exp(3, DW'(32'h03F0 + k), UW'(32'h03F0 + k));
      add_exp(0, DW'(32'h00F0 + k), UW'(32'h00F0 + k));
    end
    wait_drain("single_beat", 60);

    // Async reset mid-packet, then arbitration restarts from requester 0
    @(negedge clk); #2;
    base = beats_seen;
    for (int b = 0; b < 4; b++) add_src(2, DW'(32'h50 + b), UW'(32'h0250 + b), b == 3, 0);
    for (int b = 0; b < 4; b++) add_exp(2, DW'(32'h50 + b), UW'(32'h0250 + b));
    wait_beats("areset", base + 2, 50);
    rst_n = 1'b0;
    flush = 1'b1;
    #1;
    chk("arst_t_valid", t_valid, 0);
    chk("arst_t_data", t_data, 0);
    chk("arst_t_user", t_user, 0);
    chk("arst_grant_id", grant_id, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 0);
    exp_q.delete();
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    add_src(1, 'h71, 16'h0171, 1'b1, 0);
    add_src(3, 'h73, 16'h0373, 1'b1, 0);
    add_src(0, 'h70, 16'h0070, 1'b1, 0);
    add_exp(0, 'h70, 16'h0070);
    add_exp(1, 'h71, 16'h0171);
    add_exp(3, 'h73, 16'h0373);
    wait_drain("post_reset", 50);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
